// File: rtl/aes_pkg.sv
// Shared widths and controller state type for the AES arbiter slice.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// otherwise the lowest asserted request (wrap-around). The pointer itself
// is owned by the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic          hi_any;
    logic [IW-1:0] hi_idx;
    logic          lo_any;
    logic [IW-1:0] lo_idx;

    // Scan downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = IW'(i);
                if (IW'(i) >= ptr) begin
                    hi_any = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
    end

    // Prefer the search segment starting at ptr; fall back to the wrapped one.
    always_comb begin
        any          = lo_any;
        grant_idx    = hi_any ? hi_idx : lo_idx;
        grant_onehot = '0;
        if (lo_any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_arbiter_ctrl.sv
// Shares one combinational AES-128 core between NUM_REQ requesters.
// Grants round-robin, registers the winner's plaintext/key onto the core,
// waits SETTLE_CYCLES for the multicycle core path, captures the result
// and returns it with the owner's ID on a valid/ready channel.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; ready offered to the round-robin winner
// SETTLE | core inputs held stable, cnt counting down to capture
// RESP   | ciphertext held on rsp_*, waiting for rsp_ready
module aes_arbiter_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_plaintext,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AES_BLOCK_W-1:0]         rsp_ciphertext,
    output logic [ID_W-1:0]                rsp_id,
    output logic [AES_BLOCK_W-1:0]         core_plaintext,
    output logic [AES_KEY_W-1:0]           core_key,
    input  logic [AES_BLOCK_W-1:0]         core_ciphertext,
    output logic                           busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("aes_arbiter_ctrl: NUM_REQ must be >= 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("aes_arbiter_ctrl: SETTLE_CYCLES must be >= 1");
    end

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               accept;
    logic               settle_done;
    logic [ID_W-1:0]    ptr_after;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_arbiter (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any          (arb_any)
    );

    // Transaction events and the pointer value that follows the current winner.
    always_comb begin
        accept      = (state == IDLE) && arb_any;
        settle_done = (state == SETTLE) && (cnt == CNT_W'(1));
        ptr_after   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any)             state_nxt = SETTLE;
            SETTLE:  if (cnt == CNT_W'(1))    state_nxt = RESP;
            RESP:    if (rsp_ready)           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; no ready while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req_ready = arb_onehot;
                end
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: core inputs move only at accept so the core never sees a glitch;
    // the response is captured once the settle window has elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            cnt            <= '0;
            core_plaintext <= '0;
            core_key       <= '0;
            rsp_ciphertext <= '0;
            rsp_id         <= '0;
        end else begin
            if (accept) begin
                core_plaintext <= req_plaintext[arb_idx*AES_BLOCK_W +: AES_BLOCK_W];
                core_key       <= req_key[arb_idx*AES_KEY_W +: AES_KEY_W];
                rsp_id         <= arb_idx;
                cnt            <= CNT_W'(SETTLE_CYCLES);
                rr_ptr         <= ptr_after;
            end else if (state == SETTLE) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (settle_done) begin
                rsp_ciphertext <= core_ciphertext;
            end
        end
    end

endmodule
